jk_drive_seq: RTL and testbench

Serial excitation driver for a downstream JK flip-flop stage: accepts a WIDTH-bit target pattern through a load/ready handshake and derives per-cycle J/K values so the flop's Q reproduces the pattern, LSB first. It also reads the flop's Q back, compares it against the expected bit, and flags the first mismatch. This is the write side of the JK flop cell: the cell consumes J/K, and this block produces them and checks the result.

---
 rtl/jk_drive_seq_if.sv | 27 ++
 rtl/jk_drive_seq.sv | 147 ++++++++++++++
 tb/tb_jk_drive_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/jk_drive_seq_if.sv
// Handshake and flop-side signal bundle for jk_drive_seq.
// The master side (stimulus plus downstream flop) drives load/pattern/q_fb; the driver is the slave.
interface jk_drive_seq_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
);
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic             q_fb;
  logic             ready;
  logic             busy;
  logic             j;
  logic             k;
  logic             done;
  logic             mismatch;
  logic [IDXW-1:0]  err_idx;

  modport master (
    output load, pattern, q_fb,
    input  ready, busy, j, k, done, mismatch, err_idx
  );

  modport slave (
    input  load, pattern, q_fb,
    output ready, busy, j, k, done, mismatch, err_idx
  );
endinterface

// File: rtl/jk_drive_seq.sv
// Serial J/K excitation driver: replays a latched pattern LSB first into a downstream JK flop
// and checks the flop's Q two edges after each bit is issued, latching the first failing index.
module jk_drive_seq #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  jk_drive_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [IDXW:0] DRIVE_LEN = WIDTH[IDXW:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q,   pat_d;
  logic             cur_q,   cur_d;
  logic [IDXW:0]    cnt_q,   cnt_d;
  logic             j_q,     j_d;
  logic             k_q,     k_d;
  logic             done_q,  done_d;
  logic             mis_q,   mis_d;
  logic [IDXW-1:0]  err_q,   err_d;
  // Two-stage compare pipeline: stage 1 is the bit just issued, stage 2 the bit the flop now holds.
  logic             v1_q,    v1_d;
  logic             exp1_q,  exp1_d;
  logic [IDXW-1:0]  i1_q,    i1_d;
  logic             v2_q,    v2_d;
  logic             exp2_q,  exp2_d;
  logic [IDXW-1:0]  i2_q,    i2_d;

  // Returns {j, k}; a toggle (11) is never produced since cur always differs from or equals tgt.
  function automatic logic [1:0] excite(input logic tgt, input logic cur);
    return {tgt & ~cur, ~tgt & cur};
  endfunction

  // NOTE: every variable assigned here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    done_d  = 1'b0;
    mis_d   = mis_q;
    err_d   = err_q;
    v1_d    = 1'b0;
    exp1_d  = exp1_q;
    i1_d    = i1_q;
    v2_d    = v1_q;
    exp2_d  = exp1_q;
    i2_d    = i1_q;

    if (v2_q && (bus.q_fb != exp2_q) && !mis_q) begin
      mis_d = 1'b1;
      err_d = i2_q;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          // The flop's present Q seeds the model; bit 0 is issued on this same edge.
          {j_d, k_d} = excite(bus.pattern[0], bus.q_fb);
          cur_d      = bus.pattern[0];
          pat_d      = bus.pattern >> 1;
          cnt_d      = {{IDXW{1'b0}}, 1'b1};
          mis_d      = 1'b0;
          err_d      = '0;
          v1_d       = 1'b1;
          exp1_d     = bus.pattern[0];
          i1_d       = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LEN) begin
          state_d = DRAIN;
        end else begin
          {j_d, k_d} = excite(pat_q[0], cur_q);
          cur_d      = pat_q[0];
          pat_d      = pat_q >> 1;
          cnt_d      = cnt_q + 1'b1;
          v1_d       = 1'b1;
          exp1_d     = pat_q[0];
          i1_d       = cnt_q[IDXW-1:0];
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cur_q   <= 1'b0;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= '0;
      v1_q    <= 1'b0;
      exp1_q  <= 1'b0;
      i1_q    <= '0;
      v2_q    <= 1'b0;
      exp2_q  <= 1'b0;
      i2_q    <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      v1_q    <= v1_d;
      exp1_q  <= exp1_d;
      i1_q    <= i1_d;
      v2_q    <= v2_d;
      exp2_q  <= exp2_d;
      i2_q    <= i2_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.busy     = (state_q == DRIVE) || (state_q == DRAIN);
  assign bus.j        = j_q;
  assign bus.k        = k_q;
  assign bus.done     = done_q;
  assign bus.mismatch = mis_q;
  assign bus.err_idx  = err_q;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Bench for jk_drive_seq: a behavioural JK flop closes the loop, and expected J/K, done timing and
// first-error index are derived per sequence from the pattern, the flop's starting Q and a fault mode.
module tb_jk_drive_seq;
  localparam int W  = 8;
  localparam int IW = 3;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  // 0: healthy flop, 1: q_fb stuck at 0, 2: q_fb stuck at 1
  int   fault;
  logic flop_q;
  logic preset_en;
  logic preset_val;

  jk_drive_seq_if #(.WIDTH(W), .IDXW(IW)) bus ();

  jk_drive_seq #(.WIDTH(W), .IDXW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preset_en) flop_q <= preset_val;
    else begin
      case ({bus.j, bus.k})
        2'b10:   flop_q <= 1'b1;
        2'b01:   flop_q <= 1'b0;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end

  assign bus.q_fb = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : flop_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, " j"},        32'(bus.j),        32'd0);
    check({tag, " k"},        32'(bus.k),        32'd0);
    check({tag, " ready"},    32'(bus.ready),    32'd1);
    check({tag, " busy"},     32'(bus.busy),     32'd0);
    check({tag, " done"},     32'(bus.done),     32'd0);
    check({tag, " mismatch"}, 32'(bus.mismatch), 32'd0);
    check({tag, " err_idx"},  32'(bus.err_idx),  32'd0);
  endtask

  // Entered on a negedge: presets the flop, waits (bounded) for ready, then raises load.
  task automatic request(input logic [W-1:0] pat, input logic init);
    int t;
    preset_val = init;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
    t = 0;
    while (!bus.ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready before load", 32'(bus.ready), 32'd1);
    bus.load    = 1'b1;
    bus.pattern = pat;
  endtask

  // Expects load already raised for the coming edge (E0); walks E0..E_{W+1}.
  task automatic check_seq(input logic [W-1:0] pat, input logic init_q, input int busy_load_at,
                           input bit chain, input logic [W-1:0] next_pat);
    logic [1:0] exp_jk [W];
    logic       cur;
    logic       q_seen;
    int         first_err;
    bit         exp_busy;
    bit         exp_mis;

    cur = init_q;
    for (int i = 0; i < W; i++) begin
      if (pat[i] == cur) exp_jk[i] = 2'b00;
      else if (pat[i])   exp_jk[i] = 2'b10;
      else               exp_jk[i] = 2'b01;
      cur = pat[i];
    end
    first_err = -1;
    for (int i = 0; i < W; i++) begin
      q_seen = (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : pat[i];
      if (first_err < 0 && q_seen != pat[i]) first_err = i;
    end

    for (int n = 0; n <= W + 1; n++) begin
      @(negedge clk);
      if (n == 0 || n == busy_load_at) bus.load = 1'b0;
      if (busy_load_at > 0 && n == busy_load_at - 1) begin
        bus.load    = 1'b1;
        bus.pattern = ~pat;
      end
      if (n < W)       check($sformatf("jk bit%0d", n), 32'({bus.j, bus.k}), 32'(exp_jk[n]));
      else if (n == W) check("jk drain", 32'({bus.j, bus.k}), 32'd0);
      exp_busy = (n <= W);
      check($sformatf("busy e%0d", n),  32'(bus.busy),  32'(exp_busy));
      check($sformatf("ready e%0d", n), 32'(bus.ready), 32'(!exp_busy));
      check($sformatf("done e%0d", n),  32'(bus.done),  32'(n == W + 1));
      exp_mis = (first_err >= 0) && (n >= first_err + 2);
      check($sformatf("mismatch e%0d", n), 32'(bus.mismatch), 32'(exp_mis));
      if (exp_mis) check($sformatf("err_idx e%0d", n), 32'(bus.err_idx), 32'(first_err));
    end

    if (chain) begin
      bus.load    = 1'b1;
      bus.pattern = next_pat;
    end else begin
      @(negedge clk);
      check("done falls", 32'(bus.done), 32'd0);
      check("mismatch held idle", 32'(bus.mismatch), 32'(first_err >= 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rp;
    logic         ri;
    int           dones;

    rst         = 1'b1;
    fault       = 0;
    preset_en   = 1'b1;
    preset_val  = 1'b0;
    bus.load    = 1'b0;
    bus.pattern = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_reset("por");
    rst       = 1'b0;
    preset_en = 1'b0;

    // Nominal: flop starts at 0
    fault = 0;
    request(8'b1011_0010, 1'b0);
    check_seq(8'b1011_0010, 1'b0, 0, 1'b0, '0);

    // q_fb stuck at 0: first failure at bit 1, later bit-4 failure must not move err_idx
    fault = 1;
    request(8'b1011_0010, 1'b0);
    check_seq(8'b1011_0010, 1'b0, 0, 1'b0, '0);

    // Flop preset to 1 with all-ones target: pure hold
    fault = 0;
    request(8'hFF, 1'b1);
    check_seq(8'hFF, 1'b1, 0, 1'b0, '0);

    // Load while busy ignored; back-to-back accept in the done cycle clears mismatch, starts 8'h01
    fault = 1;
    request(8'b1011_0010, 1'b0);
    check_seq(8'b1011_0010, 1'b0, 3, 1'b1, 8'h01);
    check_seq(8'h01, 1'b0, 0, 1'b0, '0);

    // Reset mid-sequence after a mismatch has been recorded
    fault = 1;
    request(8'b1011_0010, 1'b0);
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    check("mismatch before reset", 32'(bus.mismatch), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_reset("rst edge1");
    @(negedge clk);
    check_idle_reset("rst edge2");
    rst   = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no done after reset", 32'(dones), 32'd0);
    check("idle after reset", 32'(bus.ready), 32'd1);

    // Randomized sequences across fault modes and flop start values
    for (int r = 0; r < 8; r++) begin
      rp    = W'($urandom);
      ri    = 1'($urandom_range(0, 1));
      fault = int'($urandom_range(0, 2));
      request(rp, ri);
      check_seq(rp, (fault == 1) ? 1'b0 : (fault == 2) ? 1'b1 : ri,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W)) : 0, 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
